sram_bus_bridge: RTL and testbench

Request/acknowledge bus slave that fronts the 32-bit synchronous SRAM array in the BA22 platform. It registers one bus transaction, drives the SRAM port (rd, we, byte_en, addr, wdata) for exactly one cycle, and returns a single-cycle acknowledge. For reads it also returns the data it has captured from the SRAM. It sits directly upstream of the SRAM: the processor or testbench bus master connects on one side and the SRAM ports on the other.

---
 rtl/sram_bus_bridge.sv | 133 +++++++++++++
 tb/tb_sram_bus_bridge.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_bridge.sv
// rtl/sram_bus_bridge.sv - req/ack bus slave for a 32-bit sync SRAM; SRAM_BRIDGE_RANGE_CHECK_EN adds the out-of-range error response
`timescale 1ns/1ps

module sram_bus_bridge #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  ack,
    output logic [31:0]           rdata,
    output logic                  err,
    output logic                  sram_rd,
    output logic                  sram_we,
    output logic [3:0]            sram_be,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RDW,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    sram_rd_q, sram_rd_d;
    logic                    sram_we_q, sram_we_d;
    logic [3:0]              sram_be_q, sram_be_d;
    logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
    logic [31:0]             sram_wdata_q, sram_wdata_d;
    logic                    range_err;
    logic                    unused_addr;

`ifdef SRAM_BRIDGE_RANGE_CHECK_EN
    assign range_err   = |addr[31:ADDR_WIDTH+2];
    assign unused_addr = ^addr[1:0];
`else
    // Upper address bits are dropped so accesses alias across the byte space.
    assign range_err   = 1'b0;
    assign unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
`endif

    always_comb begin
        state_d      = state_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        rdata_d      = rdata_q;
        sram_rd_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_be_d    = sram_be_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (range_err) begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                        state_d = RESP;
                    end else begin
                        sram_be_d   = be;
                        sram_addr_d = addr[ADDR_WIDTH+1:2];
                        if (we) begin
                            // Write strobe and ack share the cycle; the SRAM commits at its end.
                            sram_wdata_d = wdata;
                            sram_we_d    = 1'b1;
                            ack_d        = 1'b1;
                            state_d      = WR;
                        end else begin
                            sram_rd_d = 1'b1;
                            state_d   = RD;
                        end
                    end
                end
            end
            WR:   state_d = IDLE;
            RD:   state_d = RDW;
            RDW: begin
                rdata_d = sram_rdata;
                ack_d   = 1'b1;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0;
            sram_rd_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_be_q    <= 4'h0;
            sram_addr_q  <= '0;
            sram_wdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            sram_rd_q    <= sram_rd_d;
            sram_we_q    <= sram_we_d;
            sram_be_q    <= sram_be_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign sram_rd    = sram_rd_q;
    assign sram_we    = sram_we_q;
    assign sram_be    = sram_be_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_sram_bus_bridge.sv
// tb/tb_sram_bus_bridge.sv - self-checking bench for sram_bus_bridge
`timescale 1ns/1ps

module tb_sram_bus_bridge;

    localparam int AW    = 11;
    localparam int WORDS = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          ack;
    logic [31:0]   rdata;
    logic          err;
    logic          sram_rd;
    logic          sram_we;
    logic [3:0]    sram_be;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    sram_bus_bridge #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .we         (we),
        .be         (be),
        .addr       (addr),
        .wdata      (wdata),
        .ack        (ack),
        .rdata      (rdata),
        .err        (err),
        .sram_rd    (sram_rd),
        .sram_we    (sram_we),
        .sram_be    (sram_be),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Synchronous SRAM: read data is valid only in the cycle after sram_rd.
    logic [31:0] mem [WORDS];
    always @(posedge clk) begin : sram_model
        logic [31:0] merged;
        if (sram_we) begin
            merged = mem[sram_addr];
            for (int b = 0; b < 4; b++)
                if (sram_be[b]) merged[8*b +: 8] = sram_wdata[8*b +: 8];
            mem[sram_addr] <= merged;
        end
        if (sram_rd) sram_rdata <= mem[sram_addr];
        else         sram_rdata <= $urandom;
    end

    logic [31:0]   ref_mem [WORDS];
    logic [31:0]   last_rdata;
    int            exp_n_wr = 0, exp_n_rd = 0, exp_n_ack = 0;
    int            mon_n_wr = 0, mon_n_rd = 0, mon_n_ack = 0;
    logic [AW-1:0] cur_word;
    logic [3:0]    cur_be;
    logic [31:0]   cur_wdata;

    always @(negedge clk) begin
        check("rd_we_exclusive", 32'(sram_rd & sram_we), 32'h0);
        check("err_only_with_ack", 32'(err & ~ack), 32'h0);
        if (sram_we) begin
            mon_n_wr++;
            check("wr_sram_addr", 32'(sram_addr), 32'(cur_word));
            check("wr_sram_be", 32'(sram_be), 32'(cur_be));
            check("wr_sram_wdata", sram_wdata, cur_wdata);
        end
        if (sram_rd) begin
            mon_n_rd++;
            check("rd_sram_addr", 32'(sram_addr), 32'(cur_word));
        end
        if (ack) mon_n_ack++;
    end

    // Reference behaviour derived from the bus rules, not the FSM.
    task automatic model_txn(input logic t_we, input logic [3:0] t_be, input logic [31:0] t_addr,
                             input logic [31:0] t_wdata, output logic [31:0] e_rdata,
                             output logic e_err, output int e_lat);
        int  w;
        logic oor;
        w = int'((t_addr / 4) % WORDS);
`ifdef SRAM_BRIDGE_RANGE_CHECK_EN
        oor = (t_addr / (4 * WORDS)) != 0;
`else
        oor = 1'b0;
`endif
        exp_n_ack++;
        if (oor) begin
            e_rdata = 32'h0; e_err = 1'b1; e_lat = 1;
            last_rdata = 32'h0;
        end else if (t_we) begin
            for (int b = 0; b < 4; b++)
                if (t_be[b]) ref_mem[w][8*b +: 8] = t_wdata[8*b +: 8];
            e_rdata = last_rdata; e_err = 1'b0; e_lat = 1;
            exp_n_wr++;
        end else begin
            e_rdata = ref_mem[w]; e_err = 1'b0; e_lat = 3;
            last_rdata = e_rdata;
            exp_n_rd++;
        end
    endtask

    task automatic do_txn(input logic t_we, input logic [3:0] t_be, input logic [31:0] t_addr,
                          input logic [31:0] t_wdata, input logic hold,
                          output logic [31:0] o_rdata, output logic o_err, output int o_lat);
        int   n;
        logic got;
        @(posedge clk); #1;
        req = 1'b1; we = t_we; be = t_be; addr = t_addr; wdata = t_wdata;
        cur_word = t_addr[AW+1:2]; cur_be = t_be; cur_wdata = t_wdata;
        got = 1'b0; n = 0; o_rdata = 32'h0; o_err = 1'b0; o_lat = -1;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            if (ack) begin
                got = 1'b1; o_rdata = rdata; o_err = err; o_lat = n - 1;
                if (!hold) req = 1'b0;
            end
        end
        if (!got) req = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [31:0] g_rdata, m_rdata;
        logic        g_err, m_err;
        int          g_lat, m_lat;
        logic        hold;
        logic [31:0] r_addr;

        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 1};
        vecs[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};
        vecs[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0,         1'b0, 1};
        vecs[3]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 32'h0,         1'b0, 1};
        vecs[4]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,         32'h11BB_33DD, 1'b0, 3};
        vecs[5]  = '{1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0,         1'b0, 1};
        vecs[6]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,         32'h11BB_33DD, 1'b0, 3};
        vecs[7]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 32'h0,         1'b0, 1};
`ifdef SRAM_BRIDGE_RANGE_CHECK_EN
        vecs[8]  = '{1'b0, 4'hF, 32'h0000_2000, 32'h0,         32'h0,         1'b1, 1};
`else
        vecs[8]  = '{1'b0, 4'hF, 32'h0000_2000, 32'h0,         32'hCAFE_F00D, 1'b0, 3};
`endif
        vecs[9]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0, 3};
        vecs[10] = '{1'b0, 4'hF, 32'h0000_0023, 32'h0,         32'h11BB_33DD, 1'b0, 3};

        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        last_rdata = 32'h0;
        cur_word = '0; cur_be = 4'h0; cur_wdata = 32'h0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_sram_rd", 32'(sram_rd), 32'h0);
        check("rst_sram_we", 32'(sram_we), 32'h0);
        check("rst_sram_be", 32'(sram_be), 32'h0);
        check("rst_sram_addr", 32'(sram_addr), 32'h0);
        check("rst_sram_wdata", sram_wdata, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            model_txn(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, m_rdata, m_err, m_lat);
            do_txn(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, 1'b0, g_rdata, g_err, g_lat);
            check($sformatf("vec%0d_lat", i), 32'(g_lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_err", i), 32'(g_err), 32'(vecs[i].exp_err));
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), g_rdata, vecs[i].exp_rdata);
            else             check($sformatf("vec%0d_rdata_hold", i), g_rdata, m_rdata);
        end

        // Reset while the read strobe is on the SRAM port.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0000_0010;
        cur_word = addr[AW+1:2];
        @(posedge clk); #2;
        check("midrd_strobe_before_reset", 32'(sram_rd), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrd_sram_rd", 32'(sram_rd), 32'h0);
        check("midrd_ack", 32'(ack), 32'h0);
        check("midrd_rdata", rdata, 32'h0);
        check("midrd_sram_addr", 32'(sram_addr), 32'h0);
        req = 1'b0;
        last_rdata = 32'h0;
        repeat (3) begin
            @(negedge clk);
            check("midrd_no_ack", 32'(ack), 32'h0);
        end
        rst_n = 1'b1;
        model_txn(1'b0, 4'hF, 32'h0000_0010, 32'h0, m_rdata, m_err, m_lat);
        do_txn(1'b0, 4'hF, 32'h0000_0010, 32'h0, 1'b0, g_rdata, g_err, g_lat);
        check("postrst_rdata", g_rdata, 32'hDEAD_BEEF);
        check("postrst_lat", 32'(g_lat), 32'd3);

        // Random traffic, req frequently held high across ack.
        for (int i = 0; i < 60; i++) begin
            r_addr = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, WORDS - 1)) * 4
                                                 : 32'($urandom_range(0, 31)) * 4;
            r_addr = r_addr | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) r_addr = r_addr | (32'($urandom_range(1, 8191)) << (AW + 2));
            hold = (i != 59) && ($urandom_range(0, 1) == 1);
            we   = $urandom_range(0, 1);
            be   = 4'($urandom);
            wdata = $urandom;
            model_txn(we, be, r_addr, wdata, m_rdata, m_err, m_lat);
            do_txn(we, be, r_addr, wdata, hold, g_rdata, g_err, g_lat);
            check($sformatf("rnd%0d_lat", i), 32'(g_lat), 32'(m_lat));
            check($sformatf("rnd%0d_err", i), 32'(g_err), 32'(m_err));
            check($sformatf("rnd%0d_rdata", i), g_rdata, m_rdata);
        end
        req = 1'b0;

        repeat (4) @(negedge clk);
        check("count_sram_we", 32'(mon_n_wr), 32'(exp_n_wr));
        check("count_sram_rd", 32'(mon_n_rd), 32'(exp_n_rd));
        check("count_ack", 32'(mon_n_ack), 32'(exp_n_ack));
        for (int i = 0; i < 64; i++)
            check($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
